// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the writeback arbiter and its register
// scoreboard.
//   XLEN                 - result data width
//   NUM_REGS             - architectural register count (r0 is hard-wired 0)
//   RD_W                 - register index width
//   DEF_STARVE_LIMIT     - default count of consecutive lost ALU arbitrations
//                          after which the ALU is given priority
//   STARVE_W             - width of the starve counter
package wb_pkg;
  localparam int XLEN             = 32;
  localparam int NUM_REGS         = 32;
  localparam int RD_W             = 5;
  localparam int DEF_STARVE_LIMIT = 2;
  localparam int STARVE_W         = 2;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write tracking.
//   clk, rst            - clock, asynchronous active-high reset
//   issue_valid/rd      - an instruction that will write issue_rd is offered
//   issue_ready         - no write is pending to issue_rd (always 1 for r0)
//   clr_valid/clr_rd    - a result for clr_rd is being written this cycle
//   rnum1/rnum2         - decode-stage source indices
//   hazard1/hazard2     - the source register has a pending write
//   busy                - pending-write bit per register, bit 0 always 0
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [RD_W-1:0]     issue_rd,
  output logic                issue_ready,
  input  logic                clr_valid,
  input  logic [RD_W-1:0]     clr_rd,
  input  logic [RD_W-1:0]     rnum1,
  input  logic [RD_W-1:0]     rnum2,
  output logic                hazard1,
  output logic                hazard2,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_n;

  // busy[0] is never set, so r0 never blocks issue and never reports a hazard.
  assign issue_ready = ~busy[issue_rd];
  assign hazard1     = busy[rnum1];
  assign hazard2     = busy[rnum2];

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_ready && (issue_rd != '0))
      set_mask[issue_rd] = 1'b1;
    if (clr_valid && (clr_rd != '0))
      clr_mask[clr_rd] = 1'b1;
    // A fresh issue to a register whose stale result lands in the same cycle
    // must stay pending, so the set is applied after the clear.
    busy_n    = (busy & ~clr_mask) | set_mask;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-producer (ALU, MEM) writeback arbiter with a single
// registered register-file write port and a pending-write scoreboard.
//   clk, rst                     - clock, asynchronous active-high reset
//   issue_valid/issue_rd/ready   - instruction issue into the scoreboard
//   alu_valid/rd/data/ready      - ALU result channel
//   mem_valid/rd/data/ready      - MEM result channel
//   wnum/wdata                   - register-file write, wnum=0 means no write
//   busy                         - pending-write bits
//   rnum1/rnum2, hazard1/hazard2 - decode-stage hazard lookup
//
// Handshake: a beat transfers in any cycle where its valid and ready are both
// high. ready depends only on the other producer's valid and the starve
// counter, never on the producer's own valid, and is low only when the other
// producer would win this cycle. rd/data are ignored while valid is low.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [RD_W-1:0]     issue_rd,
  output logic                issue_ready,
  input  logic                alu_valid,
  input  logic [RD_W-1:0]     alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [RD_W-1:0]     mem_rd,
  input  logic [XLEN-1:0]     mem_data,
  output logic                mem_ready,
  output logic [RD_W-1:0]     wnum,
  output logic [XLEN-1:0]     wdata,
  output logic [NUM_REGS-1:0] busy,
  input  logic [RD_W-1:0]     rnum1,
  input  logic [RD_W-1:0]     rnum2,
  output logic                hazard1,
  output logic                hazard2
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve;
  logic [STARVE_W-1:0] starve_n;
  logic                alu_pri;
  logic                alu_xfer;
  logic                mem_xfer;
  logic                xfer;
  logic [RD_W-1:0]     xfer_rd;
  logic [XLEN-1:0]     xfer_data;

  // MEM has priority unless the ALU has been starved for STARVE_LIMIT cycles.
  assign alu_pri   = (starve == LIMIT);
  assign alu_ready = ~(mem_valid && !alu_pri);
  assign mem_ready = ~(alu_valid && alu_pri);
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;
  assign xfer      = alu_xfer || mem_xfer;

  always_comb begin
    xfer_rd   = '0;
    xfer_data = '0;
    if (alu_xfer) begin
      xfer_rd   = alu_rd;
      xfer_data = alu_data;
    end else if (mem_xfer) begin
      xfer_rd   = mem_rd;
      xfer_data = mem_data;
    end
    // Counts only while the ALU is waiting and losing; any ALU transfer or
    // ALU going idle restarts the count. It cannot pass LIMIT because the
    // ALU cannot lose once it reaches it.
    starve_n = '0;
    if (alu_valid && !alu_ready)
      starve_n = starve + 1'b1;
  end

  // Writes to r0 are accepted but presented as "no write" with zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
      wnum   <= '0;
      wdata  <= '0;
    end else begin
      starve <= starve_n;
      if (xfer && (xfer_rd != '0)) begin
        wnum  <= xfer_rd;
        wdata <= xfer_data;
      end else begin
        wnum  <= '0;
        wdata <= '0;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .clr_valid   (xfer),
    .clr_rd      (xfer_rd),
    .rnum1       (rnum1),
    .rnum2       (rnum2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .busy        (busy)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter (STARVE_LIMIT = 2).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later,
// well clear of both clock edges.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                issue_valid;
  logic [RD_W-1:0]     issue_rd;
  logic                issue_ready;
  logic                alu_valid;
  logic [RD_W-1:0]     alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                alu_ready;
  logic                mem_valid;
  logic [RD_W-1:0]     mem_rd;
  logic [XLEN-1:0]     mem_data;
  logic                mem_ready;
  logic [RD_W-1:0]     wnum;
  logic [XLEN-1:0]     wdata;
  logic [NUM_REGS-1:0] busy;
  logic [RD_W-1:0]     rnum1;
  logic [RD_W-1:0]     rnum2;
  logic                hazard1;
  logic                hazard2;

  int n_cmp = 0;
  int n_err = 0;

  // Clock
  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .wnum        (wnum),
    .wdata       (wdata),
    .busy        (busy),
    .rnum1       (rnum1),
    .rnum2       (rnum2),
    .hazard1     (hazard1),
    .hazard2     (hazard2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i = 1 means MEM wins cycle i with both producers valid continuously.
  logic [5:0]      pat;
  logic [RD_W-1:0] prev_rd;
  logic [31:0]     prev_data;

  initial begin
    // Reset block
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rnum1 = '0; rnum2 = '0;
    pat = 6'b011011;
    prev_rd = '0;
    prev_data = '0;
    tick();
    tick();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    #1;
    chk("rst_wnum", 32'(wnum), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    mem_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("post_rst_wnum", 32'(wnum), 32'd0);

    // ALU beat rd=5 -> written one cycle later, then nothing
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_ready_idle", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0; alu_rd = 5'd17; alu_data = 32'h5555;
    #1;
    chk("alu_wnum", 32'(wnum), 32'd5);
    chk("alu_wdata", wdata, 32'hDEADBEEF);
    chk("alu_busy_noop", busy, 32'd0);
    tick();
    chk("alu_wnum_after", 32'(wnum), 32'd0);
    chk("alu_wdata_after", wdata, 32'd0);

    // Issue rd=7, hazard/issue block, MEM beat clears it
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("iss7_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0; rnum1 = 5'd7; rnum2 = 5'd0;
    #1;
    chk("iss7_busy", busy, 32'h0000_0080);
    chk("iss7_ready_blocked", 32'(issue_ready), 32'd0);
    chk("iss7_hazard1", 32'(hazard1), 32'd1);
    chk("iss7_hazard2_r0", 32'(hazard2), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1111_2222;
    #1;
    chk("mem7_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("mem7_busy", busy, 32'd0);
    chk("mem7_issue_ready", 32'(issue_ready), 32'd1);
    chk("mem7_hazard1", 32'(hazard1), 32'd0);
    chk("mem7_wnum", 32'(wnum), 32'd7);
    chk("mem7_wdata", wdata, 32'h1111_2222);
    issue_rd = 5'd0;
    #1;
    chk("r0_issue_ready", 32'(issue_ready), 32'd1);

    // Both valid continuously: MEM, MEM, ALU, repeating
    tick();
    alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd1; mem_rd = 5'd2;
    for (int i = 0; i < 6; i++) begin
      alu_data = 32'h100 + 32'(i);
      mem_data = 32'h200 + 32'(i);
      #1;
      chk($sformatf("arb_mem_ready_%0d", i), 32'(mem_ready), 32'(pat[i]));
      chk($sformatf("arb_alu_ready_%0d", i), 32'(alu_ready), 32'(!pat[i]));
      if (i > 0) begin
        chk($sformatf("arb_wnum_%0d", i), 32'(wnum), 32'(prev_rd));
        chk($sformatf("arb_wdata_%0d", i), wdata, prev_data);
      end
      prev_rd   = pat[i] ? 5'd2 : 5'd1;
      prev_data = pat[i] ? (32'h200 + 32'(i)) : (32'h100 + 32'(i));
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("arb_wnum_last", 32'(wnum), 32'(prev_rd));
    chk("arb_wdata_last", wdata, prev_data);

    // ALU going idle clears the starve count
    tick();
    alu_valid = 1'b1; mem_valid = 1'b1;
    tick();
    tick();
    alu_valid = 1'b0;
    tick();
    alu_valid = 1'b1;
    #1;
    chk("starve_clr_alu_ready", 32'(alu_ready), 32'd0);
    chk("starve_clr_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();

    // Beat to r0 is accepted but does not write or touch busy
    issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    chk("r0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    #1;
    chk("r0_wnum", 32'(wnum), 32'd0);
    chk("r0_wdata", wdata, 32'd0);
    chk("r0_busy", busy, 32'h0000_0040);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("r6_busy_clr", busy, 32'd0);

    // Same cycle: issue rd=9 and ALU beat to pending rd=4
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    rnum2 = 5'd9;
    #1;
    chk("dual_busy_before", busy, 32'h0000_0010);
    chk("dual_issue_ready", 32'(issue_ready), 32'd1);
    chk("dual_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0;
    #1;
    chk("dual_busy", busy, 32'h0000_0200);
    chk("dual_wnum", 32'(wnum), 32'd4);
    chk("dual_wdata", wdata, 32'h44);
    chk("dual_hazard2", 32'(hazard2), 32'd1);

    // Issue rd=3, then reset while a MEM beat to rd=3 is being accepted
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    #1;
    chk("rstmid_busy_before", busy, 32'h0000_0208);
    chk("rstmid_mem_ready", 32'(mem_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy_async", busy, 32'd0);
    chk("rstmid_wnum_async", 32'(wnum), 32'd0);
    chk("rstmid_mem_ready_in_rst", 32'(mem_ready), 32'd1);
    tick();
    chk("rstmid_wnum_edge", 32'(wnum), 32'd0);
    chk("rstmid_wdata_edge", wdata, 32'd0);
    mem_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rstrel_wnum", 32'(wnum), 32'd0);
    chk("rstrel_wdata", wdata, 32'd0);
    chk("rstrel_busy", busy, 32'd0);

    // Starve counter restarts from 0 after reset
    alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd1; mem_rd = 5'd2;
    #1;
    chk("rstrel_arb_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL expose parameter: STARVE_LIMIT, default 2, consecutive lost ALU arbitrations before ALU gets priority.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 ISSUE_VALID  in  1  instruction issued that will write ISSUE_RD.
REQ-005 ISSUE_RD  in  5  destination register of issued instruction.
REQ-006 ISSUE_READY  out  1  issue accepted (no pending write to ISSUE_RD).
REQ-007 ALU_VALID / MEM_VALID  in  1 each  producer offers a result.
REQ-008 ALU_RD / MEM_RD  in  5 each  result destination register.
REQ-009 ALU_DATA / MEM_DATA  in  32 each  result value.
REQ-010 ALU_READY / MEM_READY  out  1 each  result accepted this cycle.
REQ-011 WNUM  out  5  register-file write index, 0 = no write.
REQ-012 WDATA  out  32  register-file write data.
REQ-013 BUSY  out  32  per-register pending-write bits, bit 0 tied 0.
REQ-014 RNUM1 / RNUM2  in  5 each  decode-stage source indices.
REQ-015 HAZARD1 / HAZARD2  out  1 each  source register has pending write.

Function
REQ-016 A producer beat SHALL transfer when VALID and READY are both high in the same cycle.
REQ-017 At most one beat SHALL transfer per cycle.
REQ-018 Default priority SHALL be MEM over ALU.
REQ-019 A 2-bit starve counter SHALL increment when ALU_VALID is high and ALU loses arbitration, and clear on any ALU transfer or when ALU_VALID is low.
REQ-020 When starve counter equals STARVE_LIMIT, ALU SHALL win over MEM that cycle.
REQ-021 READY outputs SHALL be combinational from VALIDs and starve counter; a producer SHALL see READY=0 only when the other wins.
REQ-022 A transferred beat SHALL appear on WNUM/WDATA exactly one cycle later (registered, latency 1).
REQ-023 In cycles following no transfer, WNUM SHALL be 0 and WDATA SHALL be 0.
REQ-024 A beat with RD=0 SHALL be accepted, produce WNUM=0 and WDATA=0, and leave BUSY unchanged.
REQ-025 ISSUE_READY SHALL equal NOT BUSY[ISSUE_RD] (registered BUSY), and SHALL be 1 when ISSUE_RD=0.
REQ-026 An issue (ISSUE_VALID & ISSUE_READY, RD≠0) SHALL set BUSY[RD] on the next edge.
REQ-027 A transferred beat with RD≠0 SHALL clear BUSY[RD] on the next edge, at the same edge WNUM/WDATA present the write.
REQ-028 A beat to a register not pending SHALL still be written; BUSY clear is a no-op.
REQ-029 Same-cycle issue to R and transfer to R SHALL not occur for issue (ISSUE_READY=0); same-cycle issue to R and transfer to S≠R SHALL both take effect.
REQ-030 HAZARDn SHALL equal BUSY[RNUMn], combinational, 0 for RNUMn=0.
REQ-031 Producer inputs SHALL be ignored when VALID is low.

Reset
REQ-032 Asserting rst SHALL immediately force WNUM=0, WDATA=0, BUSY=0, starve counter=0.
REQ-033 A beat accepted in the cycle rst asserts SHALL be discarded; no write SHALL occur after reset release until a new transfer.
REQ-034 During rst, READY outputs SHALL still follow REQ-021; transfers SHALL have no effect.

Structure
REQ-035 Shared package wb_pkg SHALL hold XLEN=32, NUM_REGS=32, RD_W=5, STARVE_LIMIT default.
REQ-036 Scoreboard (BUSY set/clear, HAZARD lookup, ISSUE_READY) SHALL be sub-module wb_scoreboard; arbitration and write register remain in wb_arbiter.

Verification
REQ-037 Reset, ALU beat RD=5 DATA=0xDEADBEEF -> next cycle WNUM=5 WDATA=0xDEADBEEF, then WNUM=0.
REQ-038 Issue RD=7, next cycle ISSUE_RD=7 -> ISSUE_READY=0, HAZARD1=1 with RNUM1=7; MEM beat RD=7 -> BUSY[7]=0 one edge later, ISSUE_READY=1.
REQ-039 ALU and MEM valid continuously -> MEM wins cycles 1-2, ALU wins cycle 3, pattern repeats.
REQ-040 Beat RD=0 DATA=0x1234 -> WNUM=0 WDATA=0, BUSY unchanged.
REQ-041 Issue RD=3 then rst pulse mid-stream with MEM beat RD=3 accepted -> after release BUSY=0, WNUM=0, no write.
REQ-042 Same cycle: issue RD=9 and ALU beat RD=4 (pending) -> next cycle BUSY[9]=1, BUSY[4]=0, WNUM=4.
